// File: rtl/parking_exit_gate_if.sv
// Exit gate signal bundle: sensors, code digits and entry pulse in;
// barrier, LEDs, 7-seg digits and occupancy out.
interface parking_exit_gate_if;
  logic       Exit_Sensor;
  logic       Clear_Sensor;
  logic       car_entered;
  logic       attendant_ack;
  logic [1:0] pay_1;
  logic [1:0] pay_2;
  logic       gate_open;
  logic       G_LED;
  logic       R_LED;
  logic [6:0] HEX_1;
  logic [6:0] HEX_2;
  logic [7:0] occupancy;
  logic       lot_full;

  modport master (
    output Exit_Sensor, Clear_Sensor, car_entered,
    output attendant_ack, pay_1, pay_2,
    input  gate_open, G_LED, R_LED, HEX_1, HEX_2,
    input  occupancy, lot_full
  );

  modport slave (
    input  Exit_Sensor, Clear_Sensor, car_entered,
    input  attendant_ack, pay_1, pay_2,
    output gate_open, G_LED, R_LED, HEX_1, HEX_2,
    output occupancy, lot_full
  );
endinterface

// File: rtl/parking_exit_gate.sv
// Exit gate controller: occupancy tracking, exit code check, lockout.
// Ports: clock_in, rst_in (async low), bus (parking_exit_gate_if.slave).
module parking_exit_gate #(
  parameter int         CAPACITY     = 20,
  parameter logic [1:0] CODE_1       = 2'b10,
  parameter logic [1:0] CODE_2       = 2'b01,
  parameter int         CHECK_CYCLES = 4,
  parameter int         OPEN_TIMEOUT = 16,
  parameter int         MAX_RETRIES  = 3
) (
  input logic              clock_in,
  input logic              rst_in,
  parking_exit_gate_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_DENIED = 3'd2,
    S_OPEN   = 3'd3,
    S_LOCK   = 3'd4
  } state_t;

  localparam logic [15:0] CHK_LAST  = 16'(CHECK_CYCLES - 1);
  localparam logic [15:0] OPEN_LAST = 16'(OPEN_TIMEOUT - 1);
  localparam logic [7:0]  CAP       = 8'(CAPACITY);
  localparam logic [7:0]  MAXR      = 8'(MAX_RETRIES);

  state_t      r_state, w_next;
  logic [15:0] r_dwell;
  logic [7:0]  r_retry, w_retry_nx;
  logic [7:0]  r_occ, w_occ_nx;
  logic        r_full;
  logic        w_dec, w_inc, w_dn, w_match;

  logic        r_gate, r_g, r_r;
  logic [6:0]  r_h1, r_h2;
  logic        w_gate, w_g, w_r;
  logic [6:0]  w_h1, w_h2;

  assign w_match = (bus.pay_1 == CODE_1) &&
                   (bus.pay_2 == CODE_2);

  always_comb begin
    w_next     = r_state;
    w_retry_nx = r_retry;
    w_dec      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.Exit_Sensor && r_occ != 8'd0)
          w_next = S_CHECK;
      end
      S_CHECK: begin
        if (!bus.Exit_Sensor) begin
          w_next     = S_IDLE;
          w_retry_nx = '0;
        end else if (r_dwell == CHK_LAST) begin
          if (w_match) begin
            w_next     = S_OPEN;
            w_retry_nx = '0;
          end else begin
            w_retry_nx = r_retry + 8'd1;
            w_next     = (w_retry_nx == MAXR) ?
                         S_LOCK : S_DENIED;
          end
        end
      end
      S_DENIED: begin
        if (!bus.Exit_Sensor) begin
          w_next     = S_IDLE;
          w_retry_nx = '0;
        end else if (r_dwell == CHK_LAST) begin
          w_next = S_CHECK;
        end
      end
      S_OPEN: begin
        // Leaving OPEN on the clear edge bounds it to one decrement.
        if (bus.Clear_Sensor) begin
          w_dec  = 1'b1;
          w_next = (bus.Exit_Sensor && r_occ > 8'd1) ?
                   S_CHECK : S_IDLE;
        end else if (r_dwell == OPEN_LAST) begin
          w_next = S_IDLE;
        end
      end
      S_LOCK: begin
        if (bus.attendant_ack) begin
          w_next     = S_IDLE;
          w_retry_nx = '0;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_gate = 1'b0;
    w_g    = 1'b0;
    w_r    = 1'b0;
    w_h1   = 7'b1111111;
    w_h2   = 7'b1111111;
    case (r_state)
      S_CHECK: begin
        w_r  = 1'b1;
        w_h1 = 7'b0001100;
        w_h2 = 7'b0001000;
      end
      S_DENIED: begin
        w_r  = ~r_r;
        w_h1 = 7'b0000110;
        w_h2 = 7'b0000110;
      end
      S_OPEN: begin
        w_gate = 1'b1;
        w_g    = 1'b1;
        w_h1   = 7'b1000010;
        w_h2   = 7'b1000000;
      end
      S_LOCK: begin
        w_r  = ~r_r;
        w_h1 = 7'b1000111;
        w_h2 = 7'b1000000;
      end
      default: ;
    endcase
  end

  assign w_inc = bus.car_entered && (r_occ != CAP);
  assign w_dn  = w_dec && (r_occ != 8'd0);

  // A coincident entry and exit cancel, even at capacity.
  always_comb begin
    w_occ_nx = r_occ;
    if (!(bus.car_entered && w_dec)) begin
      if (w_inc)
        w_occ_nx = r_occ + 8'd1;
      else if (w_dn)
        w_occ_nx = r_occ - 8'd1;
    end
  end

  always_ff @(posedge clock_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_dwell <= '0;
      r_retry <= '0;
      r_occ   <= '0;
      r_full  <= 1'b0;
      r_gate  <= 1'b0;
      r_g     <= 1'b0;
      r_r     <= 1'b0;
      r_h1    <= 7'b1111111;
      r_h2    <= 7'b1111111;
    end else begin
      r_state <= w_next;
      r_dwell <= (w_next != r_state) ? 16'd0 :
                 r_dwell + 16'd1;
      r_retry <= w_retry_nx;
      r_occ   <= w_occ_nx;
      r_full  <= (w_occ_nx == CAP);
      r_gate  <= w_gate;
      r_g     <= w_g;
      r_r     <= w_r;
      r_h1    <= w_h1;
      r_h2    <= w_h2;
    end
  end

  assign bus.gate_open = r_gate;
  assign bus.G_LED     = r_g;
  assign bus.R_LED     = r_r;
  assign bus.HEX_1     = r_h1;
  assign bus.HEX_2     = r_h2;
  assign bus.occupancy = r_occ;
  assign bus.lot_full  = r_full;
endmodule

// File: tb/tb_parking_exit_gate.sv
// Scoreboard bench for parking_exit_gate: directed scenarios then
// random traffic against a behavioural model of the gate rules.
module tb_parking_exit_gate;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  parking_exit_gate_if bus ();

  parking_exit_gate dut (
    .clock_in (clk),
    .rst_in   (rst_n),
    .bus      (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [25:0] q[$];

  // Model: phase names, dwell time, failed tries, cars in lot.
  localparam int IDLE = 0, CHK = 1, DEN = 2, OPN = 3, LCK = 4;
  int       m_st, m_dw, m_rt, m_occ;
  bit       m_gate, m_g, m_r, m_full;
  bit [6:0] m_h1, m_h2;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = IDLE; m_dw = 0; m_rt = 0; m_occ = 0;
    m_gate = 0; m_g = 0; m_r = 0; m_full = 0;
    m_h1 = 7'h7f; m_h2 = 7'h7f;
  endtask

  task automatic model_step();
    int ns, o;
    bit ex, cl, ok, out;
    ex  = bus.Exit_Sensor;
    cl  = bus.Clear_Sensor;
    ok  = (bus.pay_1 == 2'b10) && (bus.pay_2 == 2'b01);
    out = 0;
    ns  = m_st;
    // what the display shows after the edge reflects the phase before it
    m_gate = (m_st == OPN);
    m_g    = (m_st == OPN);
    if (m_st == CHK) m_r = 1;
    else if (m_st == DEN || m_st == LCK) m_r = !m_r;
    else m_r = 0;
    case (m_st)
      CHK: begin m_h1 = 7'b0001100; m_h2 = 7'b0001000; end
      DEN: begin m_h1 = 7'b0000110; m_h2 = 7'b0000110; end
      OPN: begin m_h1 = 7'b1000010; m_h2 = 7'b1000000; end
      LCK: begin m_h1 = 7'b1000111; m_h2 = 7'b1000000; end
      default: begin m_h1 = 7'h7f; m_h2 = 7'h7f; end
    endcase
    if (m_st == IDLE) begin
      if (ex && m_occ > 0) ns = CHK;
    end else if (m_st == CHK || m_st == DEN) begin
      if (!ex) begin ns = IDLE; m_rt = 0; end
      else if (m_dw == 3) begin
        if (m_st == DEN) ns = CHK;
        else if (ok) begin ns = OPN; m_rt = 0; end
        else begin
          m_rt++;
          ns = (m_rt == 3) ? LCK : DEN;
        end
      end
    end else if (m_st == OPN) begin
      if (cl) begin
        out = 1;
        ns = (ex && m_occ > 1) ? CHK : IDLE;
      end else if (m_dw == 15) ns = IDLE;
    end else begin
      if (bus.attendant_ack) begin ns = IDLE; m_rt = 0; end
    end
    o = m_occ + int'(bus.car_entered) - int'(out);
    m_occ  = (o > 20) ? 20 : (o < 0) ? 0 : o;
    m_full = (m_occ == 20);
    m_dw   = (ns == m_st) ? m_dw + 1 : 0;
    m_st   = ns;
  endtask

  function automatic logic [25:0] exp_vec();
    return {m_gate, m_g, m_r, m_h1, m_h2, 8'(m_occ), m_full};
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      logic [25:0] e;
      e = q.pop_front();
      chk("outputs",
          {6'd0, bus.gate_open, bus.G_LED, bus.R_LED, bus.HEX_1,
           bus.HEX_2, bus.occupancy, bus.lot_full},
          {6'd0, e});
    end
  end

  task automatic drive(int n, bit ex, bit cl, bit en, bit ak,
                       logic [1:0] p1, logic [1:0] p2);
    repeat (n) begin
      @(negedge clk);
      bus.Exit_Sensor   = ex;
      bus.Clear_Sensor  = cl;
      bus.car_entered   = en;
      bus.attendant_ack = ak;
      bus.pay_1 = p1;
      bus.pay_2 = p2;
      model_step();
      q.push_back(exp_vec());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_gate", {31'd0, bus.gate_open}, 32'd0);
    chk("rst_occ", {24'd0, bus.occupancy}, 32'd0);
    chk("rst_hex", {18'd0, bus.HEX_1, bus.HEX_2}, {18'd0, 14'h3fff});
    chk("rst_led", {30'd0, bus.G_LED, bus.R_LED}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [1:0] P1 = 2'b10, P2 = 2'b01;

  initial begin
    bus.Exit_Sensor = 0; bus.Clear_Sensor = 0;
    bus.car_entered = 0; bus.attendant_ack = 0;
    bus.pay_1 = 0; bus.pay_2 = 0;
    model_reset();
    do_reset();
    // two cars, paid exit, car clears
    drive(1, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0);
    drive(7, 1, 0, 0, 0, P1, P2);
    drive(1, 0, 1, 0, 0, P1, P2);
    drive(3, 0, 0, 0, 0, 0, 0);
    // second car leaves, then a phantom exit on an empty lot
    drive(6, 1, 0, 0, 0, P1, P2);
    drive(1, 0, 1, 0, 0, P1, P2);
    drive(6, 1, 0, 0, 0, 0, 0);
    // wrong code held into lockout, ack releases
    drive(1, 0, 0, 1, 0, 0, 0);
    drive(34, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 0);
    drive(2, 0, 0, 0, 0, 0, 0);
    // open timeout without clear
    drive(5, 1, 0, 0, 0, P1, P2);
    drive(20, 0, 0, 0, 0, 0, 0);
    // tailgate at occupancy 3 and at occupancy 1
    drive(2, 0, 0, 1, 0, 0, 0);
    drive(6, 1, 0, 0, 0, P1, P2);
    drive(1, 1, 1, 0, 0, P1, P2);
    drive(2, 0, 0, 0, 0, 0, 0);
    drive(6, 1, 0, 0, 0, P1, P2);
    drive(1, 1, 1, 0, 0, P1, P2);
    drive(6, 1, 0, 0, 0, P1, P2);
    drive(1, 1, 1, 0, 0, P1, P2);
    drive(3, 0, 0, 0, 0, 0, 0);
    // fill past capacity, then coincident entry and exit
    drive(23, 0, 0, 1, 0, 0, 0);
    drive(6, 1, 0, 0, 0, P1, P2);
    drive(1, 0, 1, 1, 0, P1, P2);
    drive(6, 1, 0, 0, 0, P1, P2);
    drive(1, 0, 0, 0, 0, 0, 0);
    // reset while the gate is open
    drive(5, 1, 0, 0, 0, P1, P2);
    @(posedge clk);
    #1;
    chk("open_before_rst", {31'd0, bus.gate_open}, 32'd1);
    do_reset();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit ex, cl, en, ak;
      logic [1:0] p1, p2;
      ex = ($urandom_range(0, 9) < 7);
      cl = ($urandom_range(0, 9) < 2);
      en = ($urandom_range(0, 9) < 3);
      ak = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 1) begin p1 = P1; p2 = P2; end
      else begin p1 = 2'($urandom); p2 = 2'($urandom); end
      drive(1, ex, cl, en, ak, p1, p2);
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
